// File: rtl/serial_sub_nbit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = operand producer / result consumer side, slave = subtractor side.
interface serial_sub_nbit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, Ovf
    );
endinterface

// File: rtl/serial_sub_nbit.sv
// Bit-serial subtractor: Diff = A - B - Bin, one full-subtractor step per clock,
// LSB first, with valid/ready handshakes on operand and result sides.
module serial_sub_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_nbit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic               br_msb_q, br_msb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               d_bit;
    logic               br_next;

    // One full-subtractor cell on the current LSBs
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        br_d        = br_q;
        br_msb_d    = br_msb_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.Bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cnt == WIDTH means every bit is done; publish result on DONE entry
                if (cnt_q == CNT_W'(WIDTH)) begin
                    diff_d      = res_q;
                    bout_d      = br_q;
                    ovf_d       = br_msb_q ^ br_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    res_d = {d_bit, res_q[WIDTH-1:1]};
                    a_d   = a_q >> 1;
                    b_d   = b_q >> 1;
                    br_d  = br_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        br_msb_d = br_q;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= 1'b0;
            br_msb_q    <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            br_q        <= br_d;
            br_msb_q    <= br_msb_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_serial_sub_nbit.sv
// Scoreboard bench for serial_sub_nbit: driver pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_serial_sub_nbit;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    serial_sub_nbit_if #(.WIDTH(W)) bus ();

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t       e;
        logic [W:0] r;
        int         sd;
        r      = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.diff = r[W-1:0];
        e.bout = r[W];
        e.ovf  = (sd < -128) || (sd > 127);
        return e;
    endfunction

    // Result monitor
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("diff", 32'(bus.Diff), 32'(e.diff));
                chk("bout", 32'(bus.Bout), 32'(e.bout));
                chk("ovf",  32'(bus.Ovf),  32'(e.ovf));
            end
        end
    end

    // Present operands, push expectation once acceptance is certain; returns #1 after accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
        e.diff = ed;
        e.bout = eb;
        e.ovf  = eo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = ~b;
        bus.Bin      = ~bin;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   lat;
        exp_t e;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff",      32'(bus.Diff),      32'd0);
        chk("rst_bout",      32'(bus.Bout),      32'd0);
        chk("rst_ovf",       32'(bus.Ovf),       32'd0);

        // 100 - 37, with latency measurement
        send(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd9);
        drain();

        send(8'd5,   8'd10,  1'b0, 8'hFB, 1'b1, 1'b0);
        send(8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1);
        send(8'h00,  8'h00,  1'b1, 8'hFF, 1'b1, 1'b0);
        drain();
        send(8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_during_shift", 32'(bus.Diff), 32'hFF);
        drain();

        // Backpressure: result held, new operands ignored while in DONE
        bus.out_ready = 1'b0;
        send(8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.A        = 8'h11;
            bus.B        = 8'h22;
            bus.Bin      = 1'b0;
            #1;
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_diff",      32'(bus.Diff),      32'h20);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        send(8'h11, 8'h22, 1'b0, 8'hEF, 1'b1, 1'b0);
        drain();

        // Reset at cnt=4 aborts the operation with no result
        send(8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        e = exp_q.pop_back();
        chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_diff",      32'(bus.Diff),      32'd0);
        chk("abort_bout",      32'(bus.Bout),      32'd0);
        chk("abort_ovf",       32'(bus.Ovf),       32'd0);
        repeat (15) @(negedge clk);
        send(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0);
        drain();

        // Random operands against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a, b;
            logic         bin;
            a   = W'($urandom_range(255));
            b   = W'($urandom_range(255));
            bin = 1'($urandom_range(1));
            e   = model(a, b, bin);
            send(a, b, bin, e.diff, e.bout, e.ovf);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
